// File: rtl/adder_acc_pkg.sv
// -----------------------------------------------------------------------------
// adder_acc_pkg
// Shared definitions for the adder-sum accumulator slice.
//   - acc_state_e  : accumulator control states (IDLE, ACCUM, HOLD), 2 bits
//   - SAMPLE_WIDTH : width of one {overflow, sum} sample
//   - DEF_*        : default parameter values for the accumulator
// -----------------------------------------------------------------------------
package adder_acc_pkg;

  localparam int SAMPLE_WIDTH    = 9;
  localparam int DEF_NUM_SAMPLES = 4;
  localparam int DEF_ACC_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

endpackage : adder_acc_pkg

// File: rtl/flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
// Up-counter with synchronous clear and a programmable rollover value.
// Ports:
//   clk, n_rst     : clock, asynchronous active-low reset
//   clear          : synchronous clear to zero (wins over count_enable)
//   count_enable   : advance the count by one this cycle
//   rollover_val   : terminal count; the next increment after it wraps to 1
//   rollover_flag  : high in the cycle whose increment lands on rollover_val
// -----------------------------------------------------------------------------
module flex_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic             rollover_flag
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? ONE : count_q + ONE;
    end
  end

  // Flag is combinational so the owner can act on the same edge that
  // performs the terminal increment.
  assign rollover_flag = count_enable & ~clear & (count_q == rollover_val - ONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : flex_counter

// File: rtl/adder_sum_accumulator.sv
// -----------------------------------------------------------------------------
// adder_sum_accumulator
// Accumulates NUM_SAMPLES 9-bit {overflow, sum} samples from the adder stage
// into a saturating ACC_WIDTH-bit total, then holds it under valid/ack.
// Ports:
//   clk, n_rst      : clock, asynchronous active-low reset
//   sample_valid    : sum/overflow carry a valid adder result
//   sum, overflow   : adder result; overflow has weight 256
//   clear           : synchronous abort of the current window (top priority)
//   sample_ready    : a sample can be accepted this cycle (low while holding)
//   result          : accumulated total, stable while result_valid is high
//   result_valid    : total available
//   result_ack      : consumer takes the total
//   saturated       : current or held window clipped at all ones
//   busy            : a window is in progress (at least one sample taken)
// -----------------------------------------------------------------------------
module adder_sum_accumulator
  import adder_acc_pkg::*;
#(
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sample_valid,
  input  logic [7:0]           sum,
  input  logic                 overflow,
  input  logic                 clear,
  output logic                 sample_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 result_valid,
  input  logic                 result_ack,
  output logic                 saturated,
  output logic                 busy
);

  localparam int CNT_WIDTH = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_WIDTH-1:0] ROLLOVER = CNT_WIDTH'(NUM_SAMPLES);

  acc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic                 sat_q, sat_d;

  logic                 accept;
  logic                 hold_release;
  logic                 window_done;
  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH:0]   sum_wide;
  logic                 clip;
  logic [ACC_WIDTH-1:0] add_sat;

  assign sample_ready = (state_q != HOLD);
  // A sample arriving together with clear is dropped, so it never counts.
  assign accept       = sample_valid & sample_ready & ~clear;
  assign hold_release = (state_q == HOLD) & result_ack;

  // Saturating add: one extra bit catches the carry out of the accumulator.
  assign sample_ext = ACC_WIDTH'({overflow, sum});
  assign sum_wide   = {1'b0, acc_q} + {1'b0, sample_ext};
  assign clip       = sum_wide[ACC_WIDTH];
  assign add_sat    = clip ? '1 : sum_wide[ACC_WIDTH-1:0];

  flex_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_sample_counter (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear | hold_release),
    .count_enable  (accept),
    .rollover_val  (ROLLOVER),
    .rollover_flag (window_done)
  );

  // NOTE: every next-state variable gets its hold value first, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    sat_d          = sat_q;

    if (clear) begin
      state_d        = IDLE;
      acc_d          = '0;
      result_valid_d = 1'b0;
      sat_d          = 1'b0;
    end else begin
      unique case (state_q)
        // IDLE keeps acc at zero, so the shared add path loads the first
        // sample unchanged.
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d = add_sat;
            sat_d = sat_q | clip;
            if (window_done) begin
              result_d       = add_sat;
              result_valid_d = 1'b1;
              state_d        = HOLD;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        HOLD: begin
          if (result_ack) begin
            state_d        = IDLE;
            acc_d          = '0;
            result_valid_d = 1'b0;
            sat_d          = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      sat_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      sat_q          <= sat_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign saturated    = sat_q;
  assign busy         = (state_q == ACCUM);

endmodule : adder_sum_accumulator

// File: tb/tb_adder_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_adder_sum_accumulator
// Drives two accumulators (ACC_WIDTH 16 and 10, NUM_SAMPLES 4) with the same
// stimulus and compares both against a window-level arithmetic model every
// cycle, plus directed literal expectations.
// -----------------------------------------------------------------------------
module tb_adder_sum_accumulator;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        sample_valid;
  logic [7:0]  sum;
  logic        overflow;
  logic        clear;
  logic        result_ack;

  logic        ready0, rv0, sat0, busy0;
  logic [15:0] res0;
  logic        ready1, rv1, sat1, busy1;
  logic [9:0]  res1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_sum_accumulator #(.NUM_SAMPLES(NS), .ACC_WIDTH(16)) dut0 (
    .clk          (clk),
    .n_rst        (n_rst),
    .sample_valid (sample_valid),
    .sum          (sum),
    .overflow     (overflow),
    .clear        (clear),
    .sample_ready (ready0),
    .result       (res0),
    .result_valid (rv0),
    .result_ack   (result_ack),
    .saturated    (sat0),
    .busy         (busy0)
  );

  adder_sum_accumulator #(.NUM_SAMPLES(NS), .ACC_WIDTH(10)) dut1 (
    .clk          (clk),
    .n_rst        (n_rst),
    .sample_valid (sample_valid),
    .sum          (sum),
    .overflow     (overflow),
    .clear        (clear),
    .sample_ready (ready1),
    .result       (res1),
    .result_valid (rv1),
    .result_ack   (result_ack),
    .saturated    (sat1),
    .busy         (busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Window-level model: the true (unclipped) sum of samples in the open
  // window, how many were taken, and the held outcome once a window closes.
  // ---------------------------------------------------------------------------
  longint maxv [2] = '{65535, 1023};
  int     cnt  [2];
  longint tot  [2];
  bit     hold [2];
  longint res  [2];
  bit     hsat [2];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int m = 0; m < 2; m++) begin
        cnt[m] = 0; tot[m] = 0; hold[m] = 0; res[m] = 0; hsat[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (clear) begin
          cnt[m] = 0; tot[m] = 0; hold[m] = 0; hsat[m] = 0;
        end else if (hold[m]) begin
          if (result_ack) begin
            hold[m] = 0; cnt[m] = 0; tot[m] = 0; hsat[m] = 0;
          end
        end else if (sample_valid) begin
          tot[m] += longint'(overflow) * 256 + longint'(sum);
          cnt[m]++;
          if (cnt[m] == NS) begin
            hold[m] = 1;
            hsat[m] = tot[m] > maxv[m];
            res[m]  = hsat[m] ? maxv[m] : tot[m];
            cnt[m]  = 0;
            tot[m]  = 0;
          end
        end
      end
    end
  end

  task automatic compare_one(input int m, input logic rdy, input logic rv,
                             input logic [31:0] r, input logic sat, input logic bsy);
    string p;
    p = $sformatf("dut%0d", m);
    check({p, "_sample_ready"}, 32'(rdy), 32'(!hold[m]));
    check({p, "_result_valid"}, 32'(rv), 32'(hold[m]));
    check({p, "_result"}, r, 32'(res[m]));
    check({p, "_saturated"}, 32'(sat), hold[m] ? 32'(hsat[m]) : 32'(tot[m] > maxv[m]));
    check({p, "_busy"}, 32'(bsy), 32'(!hold[m] && cnt[m] > 0));
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    compare_one(0, ready0, rv0, 32'(res0), sat0, busy0);
    compare_one(1, ready1, rv1, 32'(res1), sat1, busy1);
  end

  // Drive one cycle of inputs and wait for the next sampling point.
  task automatic drive(input bit v, input bit o, input logic [7:0] s,
                       input bit c = 1'b0, input bit a = 1'b0);
    sample_valid = v; overflow = o; sum = s; clear = c; result_ack = a;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b1;
    sample_valid = 1'b0; overflow = 1'b0; sum = '0; clear = 1'b0; result_ack = 1'b0;
    #1 n_rst = 1'b0;

    // Reset held with valid random samples present.
    repeat (4) drive(1'b1, 1'($urandom), 8'($urandom), 1'b0, 1'($urandom));
    check("rst_result", 32'(res0), 0);
    check("rst_result_valid", 32'(rv0), 0);
    check("rst_saturated", 32'(sat0), 0);
    check("rst_busy", 32'(busy0), 0);
    sample_valid = 1'b0; result_ack = 1'b0;
    n_rst = 1'b1;
    idle(1);
    check("rst_ready_after_release", 32'(ready0), 1);

    // Basic window.
    drive(1, 0, 8'd10); drive(1, 0, 8'd20); drive(1, 0, 8'd30); drive(1, 0, 8'd40);
    check("basic_valid", 32'(rv0), 1);
    check("basic_result", 32'(res0), 100);
    check("basic_saturated", 32'(sat0), 0);
    check("basic_ready", 32'(ready0), 0);
    drive(0, 0, 8'd0, 0, 1);
    check("basic_ack_valid", 32'(rv0), 0);
    check("basic_ack_ready", 32'(ready0), 1);

    // Overflow weighting with gaps.
    drive(1, 1, 8'h10); drive(1, 0, 8'hFF); idle(3); drive(1, 1, 8'h00); drive(1, 0, 8'h01);
    check("ovf_result", 32'(res0), 784);
    check("ovf_result_w10", 32'(res1), 784);
    drive(0, 0, 8'd0, 0, 1);

    // Saturation on the narrow instance only.
    repeat (4) drive(1, 1, 8'hFF);
    check("sat_result_w10", 32'(res1), 1023);
    check("sat_flag_w10", 32'(sat1), 1);
    check("sat_result_w16", 32'(res0), 2044);
    check("sat_flag_w16", 32'(sat0), 0);
    drive(0, 0, 8'd0, 0, 1);
    repeat (4) drive(1, 0, 8'd1);
    check("post_sat_result_w10", 32'(res1), 4);
    check("post_sat_flag_w10", 32'(sat1), 0);
    drive(0, 0, 8'd0, 0, 1);

    // Clear mid-window drops the coincident sample.
    drive(1, 0, 8'd50); drive(1, 0, 8'd60);
    drive(1, 0, 8'd70, 1, 0);
    check("clear_busy", 32'(busy0), 0);
    drive(1, 0, 8'd1); drive(1, 0, 8'd2); drive(1, 0, 8'd3); drive(1, 0, 8'd4);
    check("clear_new_result", 32'(res0), 10);

    // Backpressure while holding.
    repeat (5) drive(1, 0, 8'd99);
    check("hold_result", 32'(res0), 10);
    check("hold_valid", 32'(rv0), 1);
    drive(1, 0, 8'd99, 0, 1);
    check("hold_ack_valid", 32'(rv0), 0);
    check("hold_ack_dropped", 32'(busy0), 0);
    drive(1, 0, 8'd5);
    check("hold_next_window", 32'(busy0), 1);

    // Asynchronous reset mid-window.
    drive(1, 0, 8'd7);
    sample_valid = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy0), 0);
    check("midrst_result", 32'(res0), 0);
    @(negedge clk);
    n_rst = 1'b1;
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom),
            $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_adder_sum_accumulator
